// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared definitions for the register-file command sequencer.
// Holds the command opcodes, the sequencer FSM states and the packed
// command width used by the command FIFO.
package rf_seq_pkg;

    // Default geometry of the 32x32 register file.
    localparam int unsigned RF_DW = 32;
    localparam int unsigned RF_AW = 5;

    // Packed command: {op[1:0], addr_a[AW-1:0], addr_b[AW-1:0], data[DW-1:0]}.
    localparam int unsigned CMD_W = 2 + 2 * RF_AW + RF_DW;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_MOVE  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    // Packed command width for a non-default geometry.
    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return 2 + 2 * aw + dw;
    endfunction

endpackage

// File: rtl/rf_cmd_sequencer_if.sv
// rf_cmd_sequencer_if: command and response channels of the sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_addr_a/cmd_addr_b/cmd_data : command channel
//   rsp_valid/rsp_ready/rsp_data                            : read response channel
// master: the command producer / response consumer; slave: the sequencer.
interface rf_cmd_sequencer_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr_a;
    logic [AW-1:0] cmd_addr_b;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rf_cmd_fifo.sv
// rf_cmd_fifo: synchronous command FIFO, first-word-fall-through head.
//   clk, rst (sync, active low) | i_push, i_din : write side
//   i_pop : advance head | o_full, o_empty, o_head : status and head entry
// Pointers carry one extra wrap bit: full when the low bits match and the
// wrap bits differ.
module rf_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_head  = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wr_ptr[PW-1:0]] <= i_din;
                r_wr_ptr                <= r_wr_ptr + (PW + 1)'(1);
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + (PW + 1)'(1);
            end
        end
    end
endmodule

// File: rtl/rf_cmd_sequencer.sv
// rf_cmd_sequencer: command front-end for the 32x32 dual-address register file.
//   clk, rst (sync, active low)
//   bus (slave)  : command channel in, read response channel out
//   rf_address_a/rf_address_b/rf_mode/rf_write/rf_din : registered rf port bundle
//   rf_out       : rf read data, valid one cycle after the address is presented
//   busy         : FIFO non-empty or FSM not idle
// Optional: define RF_SEQ_STATS_EN to add stat_wr_cnt/stat_rd_cnt saturating counters.
module rf_cmd_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_cmd_sequencer_if.slave bus,
    output logic [AW-1:0] rf_address_a,
    output logic [AW-1:0] rf_address_b,
    output logic          rf_mode,
    output logic          rf_write,
    output logic [DW-1:0] rf_din,
    input  logic [DW-1:0] rf_out,
    output logic          busy
`ifdef RF_SEQ_STATS_EN
    ,
    output logic [15:0]   stat_wr_cnt,
    output logic [15:0]   stat_rd_cnt
`endif
);
    localparam int unsigned CW = cmd_width(AW, DW);

    logic [CW-1:0] w_cmd_in;
    logic [CW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    op_e           w_head_op;
    logic [AW-1:0] w_head_a;
    logic [AW-1:0] w_head_b;
    logic [DW-1:0] w_head_data;

    state_e        r_state;
    state_e        w_state_d;
    logic          r_rd_lat;  // set during the cycle the rf samples the read address
    logic [AW-1:0] r_address_a;
    logic [AW-1:0] r_address_b;
    logic          r_mode;
    logic          r_write;
    logic [DW-1:0] r_din;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;

    assign w_cmd_in    = {bus.cmd_op, bus.cmd_addr_a, bus.cmd_addr_b, bus.cmd_data};
    assign w_head_op   = op_e'(w_head[CW-1 -: 2]);
    assign w_head_a    = w_head[DW+2*AW-1 -: AW];
    assign w_head_b    = w_head[DW+AW-1 -: AW];
    assign w_head_data = w_head[DW-1:0];

    rf_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_din   (w_cmd_in),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // No pop credit: a full FIFO refuses even when it is popped this cycle.
    assign bus.cmd_ready = !w_full;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign rf_address_a  = r_address_a;
    assign rf_address_b  = r_address_b;
    assign rf_mode       = r_mode;
    assign rf_write      = r_write;
    assign rf_din        = r_din;
    assign busy          = !w_empty || (r_state != IDLE);

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_op == OP_READ) w_state_d = RD_WAIT;
                end
            end
            RD_WAIT: if (r_rd_lat) w_state_d = RESP;
            RESP:    if (bus.rsp_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rd_lat    <= 1'b0;
            r_address_a <= '0;
            r_address_b <= '0;
            r_mode      <= 1'b0;
            r_write     <= 1'b0;
            r_din       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_write  <= 1'b0;
            r_mode   <= 1'b0;
            r_rd_lat <= 1'b0;
            if (w_pop) begin
                unique case (w_head_op)
                    OP_WRITE: begin
                        r_address_a <= w_head_a;
                        r_din       <= w_head_data;
                        r_write     <= 1'b1;
                    end
                    OP_MOVE: begin
                        r_address_a <= w_head_a;
                        r_address_b <= w_head_b;
                        r_mode      <= 1'b1;
                        r_write     <= 1'b1;
                    end
                    OP_READ: r_address_a <= w_head_a;
                    default: ;
                endcase
            end
            // First RD_WAIT cycle the rf registers the address; rf_out is valid in the second.
            if (r_state == RD_WAIT) begin
                if (!r_rd_lat) begin
                    r_rd_lat <= 1'b1;
                end else begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= rf_out;
                end
            end
            if (r_state == RESP && bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
    end

`ifdef RF_SEQ_STATS_EN
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_pop && (w_head_op == OP_WRITE || w_head_op == OP_MOVE) && r_wr_cnt != 16'hFFFF)
                r_wr_cnt <= r_wr_cnt + 16'd1;
            if (r_state == RESP && bus.rsp_ready && r_rd_cnt != 16'hFFFF)
                r_rd_cnt <= r_rd_cnt + 16'd1;
        end
    end

    assign stat_wr_cnt = r_wr_cnt;
    assign stat_rd_cnt = r_rd_cnt;
`endif
endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// tb_rf_cmd_sequencer: directed plus randomized bench for rf_cmd_sequencer,
// with a behavioural register file and a command-level reference model.
module tb_rf_cmd_sequencer;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_cmd_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    logic [AW-1:0] rf_address_a;
    logic [AW-1:0] rf_address_b;
    logic          rf_mode;
    logic          rf_write;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_out;
    logic          busy;
`ifdef RF_SEQ_STATS_EN
    logic [15:0]   stat_wr_cnt;
    logic [15:0]   stat_rd_cnt;
`endif

    rf_cmd_sequencer #(.DW(DW), .AW(AW), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rf_address_a (rf_address_a),
        .rf_address_b (rf_address_b),
        .rf_mode      (rf_mode),
        .rf_write     (rf_write),
        .rf_din       (rf_din),
        .rf_out       (rf_out),
        .busy         (busy)
`ifdef RF_SEQ_STATS_EN
        ,
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt)
`endif
    );

    // Register file: synchronous read on address_a; MOVE copies address_b into address_a.
    logic [DW-1:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_write === 1'b1) rf_mem[rf_address_a] <= rf_mode ? rf_mem[rf_address_b] : rf_din;
        rf_out <= rf_mem[rf_address_a];
    end

    // Reference model: memory image updated in command order at acceptance,
    // expected rf write events and expected read responses, in order.
    typedef struct {
        logic [4:0]  a;
        logic [4:0]  b;
        logic        mode;
        logic [31:0] d;
        logic [31:0] old;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    logic [31:0] ref_mem [32];
    int          wr_cycs[$];
    int          acc_cycs[$];
    int          rsp_rises[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          mode_cnt = 0;
    int          rsp_cycles = 0;
    bit          mon_en = 1'b0;
    bit          rnd = 1'b0;
    bit          prev_v = 1'b0;
    logic [31:0] last_rsp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            cyc++;
            if (rf_write === 1'b1) begin
                wr_cycs.push_back(cyc);
                if (rf_mode === 1'b1) mode_cnt++;
                if (wq.size() == 0) begin
                    check("rf_write_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wq.pop_front();
                    check("rf_address_a", 32'(rf_address_a), 32'(e.a));
                    check("rf_mode", 32'(rf_mode), 32'(e.mode));
                    if (e.mode) check("rf_address_b", 32'(rf_address_b), 32'(e.b));
                    else        check("rf_din", rf_din, e.d);
                end
            end else begin
                check("rf_write_idle", 32'(rf_write), 32'd0);
                check("rf_mode_idle", 32'(rf_mode), 32'd0);
            end
            if (bus.rsp_valid === 1'b1) begin
                if (!prev_v) rsp_rises.push_back(cyc);
                rsp_cycles++;
                if (rq.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rsp_data", bus.rsp_data, rq[0]);
                    last_rsp = bus.rsp_data;
                    if (bus.rsp_ready) void'(rq.pop_front());
                end
            end else begin
                check("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
            end
            prev_v = (bus.rsp_valid === 1'b1);
            if (rst !== 1'b1) begin
                // Unissued writes are discarded: roll the image back newest first.
                while (wq.size() > 0) begin
                    e = wq.pop_back();
                    ref_mem[e.a] = e.old;
                end
                rq.delete();
            end else if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cycs.push_back(cyc);
                e.a = bus.cmd_addr_a;
                e.b = bus.cmd_addr_b;
                e.d = bus.cmd_data;
                e.old = ref_mem[bus.cmd_addr_a];
                case (bus.cmd_op)
                    2'd1: begin
                        e.mode = 1'b0;
                        wq.push_back(e);
                        ref_mem[e.a] = e.d;
                    end
                    2'd3: begin
                        e.mode = 1'b1;
                        wq.push_back(e);
                        ref_mem[e.a] = ref_mem[e.b];
                    end
                    2'd2: rq.push_back(ref_mem[e.a]);
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] d);
        int  n = 0;
        bit  acc = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_addr_a = a;
        bus.cmd_addr_b = b;
        bus.cmd_data   = d;
        while (!acc && n < 200) begin
            if (rnd) bus.rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = (bus.cmd_ready === 1'b1) && (rst === 1'b1);
            tick();
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.rsp_ready = 1'b1;
        while ((busy !== 1'b0 || wq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 200), 32'd1);
        tick();
    endtask

    int wc0;
    int n;

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        // Reset held for two cycles with a command presented.
        rst            = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'd1;
        bus.cmd_addr_a = 5'd3;
        bus.cmd_addr_b = 5'd0;
        bus.cmd_data   = 32'd55;
        bus.rsp_ready  = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("reset_rf_write", 32'(rf_write), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        tick();

        // Back-to-back writes.
        wr_cycs.delete();
        acc_cycs.delete();
        send(2'd1, 5'd12, 5'd0, 32'd123456);
        send(2'd1, 5'd15, 5'd0, 32'd12345);
        wait_idle();
        check("wr_count", 32'(wr_cycs.size()), 32'd2);
        check("wr_latency", 32'(wr_cycs[0] - acc_cycs[0]), 32'd2);
        check("wr_back_to_back", 32'(wr_cycs[1] - wr_cycs[0]), 32'd1);

        // Write then read back.
        send(2'd1, 5'd2, 5'd0, 32'd1245);
        acc_cycs.delete();
        rsp_rises.delete();
        rsp_cycles = 0;
        send(2'd2, 5'd2, 5'd0, 32'd0);
        wait_idle();
        check("read_data", last_rsp, 32'd1245);
        check("read_latency", 32'(rsp_rises[0] - acc_cycs[0]), 32'd4);
        check("read_valid_cycles", 32'(rsp_cycles), 32'd1);

        // Move then read.
        mode_cnt = 0;
        send(2'd3, 5'd2, 5'd12, 32'd0);
        send(2'd2, 5'd2, 5'd0, 32'd0);
        wait_idle();
        check("move_read_data", last_rsp, 32'd123456);
        check("move_mode_pulses", 32'(mode_cnt), 32'd1);

        // Response backpressure with four writes queued behind the read.
        bus.rsp_ready = 1'b0;
        send(2'd2, 5'd15, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) send(2'd1, 5'(4 + i), 5'd0, $urandom);
        wc0 = wr_cycs.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_hold", bus.rsp_data, 32'd12345);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        check("bp_no_writes", 32'(wr_cycs.size()), 32'(wc0));
        tick();
        wait_idle();
        check("bp_writes_after", 32'(wr_cycs.size()), 32'(wc0 + 4));

        // Reset while a response is held and three commands are queued.
        bus.rsp_ready = 1'b0;
        send(2'd2, 5'd12, 5'd0, 32'd0);
        send(2'd1, 5'd20, 5'd0, 32'hA5A5_0001);
        send(2'd1, 5'd21, 5'd0, 32'hA5A5_0002);
        send(2'd1, 5'd22, 5'd0, 32'hA5A5_0003);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("mid_rsp_seen", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        wc0 = wr_cycs.size();
        repeat (10) @(negedge clk);
        check("mid_rst_no_issue", 32'(wr_cycs.size()), 32'(wc0));
        tick();
        bus.rsp_ready = 1'b1;
        send(2'd2, 5'd20, 5'd0, 32'd0);
        wait_idle();
        check("mid_rst_mem_kept", last_rsp, 32'd0);

        // Randomized traffic with random response backpressure.
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom);
        end
        rnd = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
